hist_chan_sched: RTL and testbench
==================================

# hist_chan_sched

Frame-synchronous scheduler for the histogram component selector. It drives the selector's one-hot `hist_switch` so the histogram engine sees either a fixed component (manual) or a rotation of R/G/B/Y (auto). Channel changes happen only after a completed accumulation and its readout. It also gates accumulation so every histogram covers whole frames of a single component. It sits between the control-register block and the selector/histogram pair.

## Interface
- `FRAMES_PER_CHAN`, default 1: frames accumulated per channel before readout; legal 1..255.
- `SETTLE_CYCLES`, default 4: idle cycles after a channel change; legal 1..255.
- `CHAN_MASK`, default 4'b1111: channels enabled in auto rotation. Bit0=R, bit1=G, bit2=B, bit3=Y. 4'b0000 behaves as 4'b1000.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  scheduler run enable.
- `auto_mode`  in  1  1 = rotate through CHAN_MASK; 0 = follow manual_sel.
- `manual_sel`  in  4  requested one-hot channel in manual mode.
- `frame_end_hist`  in  1  single-cycle frame-end pulse from the selector output.
- `rd_done`  in  1  single-cycle pulse from histogram readout: results consumed.
- `hist_switch`  out  4  one-hot channel select to the selector.
- `hist_gate`  out  1  histogram accumulation enable.
- `rd_start`  out  1  single-cycle readout request.
- `chan_changed`  out  1  single-cycle pulse when `hist_switch` changes.
- `frame_cnt`  out  8  frames accumulated on the current channel.

## Operation
- Reset values: `hist_switch`=4'b1000, `hist_gate`=0, `rd_start`=0, `chan_changed`=0, `frame_cnt`=0, state=IDLE.
- All outputs are registered.
- **IDLE**: `hist_gate`=0.
  - `enable`=1 and `frame_end_hist` → ALIGNED start: go to ACQ, `hist_gate`=1.
- **ACQ**: `hist_gate`=1.
  - On `frame_end_hist`, if `frame_cnt`+1 < FRAMES_PER_CHAN: `frame_cnt` increments.
  - Otherwise: `frame_cnt` goes to 0, `rd_start` pulses, `hist_gate` goes to 0, go to RD_WAIT.
- **RD_WAIT**: `hist_gate`=0; `frame_end_hist` is ignored. On `rd_done`, compute the next channel:
  - Auto mode: scan upward from the current bit (R→G→B→Y→R) and take the first set bit of CHAN_MASK. The current channel is chosen only if it is the sole mask bit. If the current channel is not in the mask, the same scan applies.
  - Manual mode: `manual_sel` if it is exactly one-hot; otherwise keep the current channel.
  - Next ≠ current: update `hist_switch`, pulse `chan_changed`, load the settle counter with SETTLE_CYCLES, go to SETTLE.
  - Next = current: go to ALIGN.
- **SETTLE**: `hist_gate`=0; `frame_end_hist` is ignored. The counter decrements; at 1, go to ALIGN.
- **ALIGN**: `hist_gate`=0. On `frame_end_hist` go to ACQ. Accumulation always starts at a frame boundary of the new source.
- **enable deasserted**:
  - In ACQ, SETTLE or ALIGN: go to IDLE next cycle. `hist_gate`=0, `frame_cnt`=0, `hist_switch` held.
  - In RD_WAIT: wait for `rd_done`, then go to IDLE without changing channel.
- Mode changes (`auto_mode`, `manual_sel`) are sampled only on `rd_done` in RD_WAIT. They never cause a mid-frame switch.
- `reset` mid-operation returns to the reset values on the next edge, including mid-settle and mid-readout. A pending `rd_done` is then ignored.

## Timing
- `frame_end_hist` sampled at edge N in ACQ (final frame) → `rd_start`=1 and `hist_gate`=0 during cycle N+1, for exactly one cycle.
- `rd_done` at edge M → new `hist_switch` and `chan_changed`=1 during cycle M+1.
- SETTLE lasts SETTLE_CYCLES cycles, then ALIGN.
- `frame_end_hist` at edge K in ALIGN or IDLE → `hist_gate`=1 from cycle K+1.
- `frame_end_hist` and `rd_done` in the same cycle in RD_WAIT: `rd_done` is honoured, `frame_end_hist` is dropped.
- `frame_end_hist` in the same cycle as `enable` falling in ACQ: `enable` wins, `rd_start` does not fire.
- `rd_done` outside RD_WAIT is ignored.

## Test plan
- Reset → `hist_switch`=4'b1000, `hist_gate`=0. Raise `enable` with no `frame_end_hist` for 100 cycles → `hist_gate` stays 0. First `frame_end_hist` → `hist_gate`=1 next cycle.
- Auto, CHAN_MASK=4'b1111, FRAMES_PER_CHAN=2, SETTLE_CYCLES=4. Drive frame ends, and `rd_done` 10 cycles after each `rd_start` → `rd_start` fires once per 2 frames. `hist_switch` sequence is 1000→0001→0010→0100→1000. `chan_changed` pulses once per change. `hist_gate`=0 for 4 settle cycles plus until the next frame end.
- Auto, CHAN_MASK=4'b0101, start at 4'b1000 → next channels are 4'b0001, 4'b0100, 4'b0001.
- Manual: `manual_sel`=4'b0010 → switch only after `rd_done`. `manual_sel`=4'b0110 → channel unchanged, no `chan_changed`, ALIGN entered.
- Simultaneous `rd_done` + `frame_end_hist` in RD_WAIT → channel advances, SETTLE entered, `hist_gate` stays 0.
- `enable` dropped in RD_WAIT → IDLE only after `rd_done`, `hist_switch` unchanged. `reset` asserted in SETTLE → all outputs at reset values next cycle.

Source files
------------

// File: rtl/hist_chan_sched.sv
// Frame-synchronous channel scheduler for the histogram component selector.
// Switches hist_switch only after a finished accumulation and its readout, and gates accumulation to whole frames.
module hist_chan_sched #(
  parameter int unsigned FRAMES_PER_CHAN = 1,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter logic [3:0]  CHAN_MASK       = 4'b1111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       auto_mode,
  input  logic [3:0] manual_sel,
  input  logic       frame_end_hist,
  input  logic       rd_done,
  output logic [3:0] hist_switch,
  output logic       hist_gate,
  output logic       rd_start,
  output logic       chan_changed,
  output logic [7:0] frame_cnt
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned NUM_CHAN = 4;
  localparam logic [3:0]  EFF_MASK = (CHAN_MASK == 4'b0000) ? 4'b1000 : CHAN_MASK;
  localparam logic [3:0]  RST_CHAN = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ,
    S_RD_WAIT,
    S_SETTLE,
    S_ALIGN
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       hist_switch_q, hist_switch_d;
  logic             hist_gate_q, hist_gate_d;
  logic             rd_start_q, rd_start_d;
  logic             chan_changed_q, chan_changed_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;

  logic [3:0] auto_next;
  logic [3:0] next_chan;
  logic [3:0] rot_cand;
  logic       auto_found;
  logic       manual_ok;
  logic       last_frame;

  // Auto rotation: first enabled channel strictly above the current one, wrapping back to itself.
  always_comb begin
    auto_next  = hist_switch_q;
    auto_found = 1'b0;
    rot_cand   = hist_switch_q;
    for (int k = 1; k <= NUM_CHAN; k++) begin
      rot_cand = 4'((hist_switch_q << k) | (hist_switch_q >> (NUM_CHAN - k)));
      if (!auto_found && ((rot_cand & EFF_MASK) != 4'b0000)) begin
        auto_next  = rot_cand;
        auto_found = 1'b1;
      end
    end
  end

  assign manual_ok  = (manual_sel != 4'b0000) && ((manual_sel & (manual_sel - 4'd1)) == 4'b0000);
  assign next_chan  = auto_mode ? auto_next : (manual_ok ? manual_sel : hist_switch_q);
  assign last_frame = (32'(frame_cnt_q) + 32'd1) >= FRAMES_PER_CHAN;

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    hist_switch_d  = hist_switch_q;
    rd_start_d     = 1'b0;
    chan_changed_d = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    settle_cnt_d   = settle_cnt_q;

    case (state_q)
      S_IDLE: begin
        frame_cnt_d = '0;
        if (enable && frame_end_hist) begin
          state_d = S_ACQ;
        end
      end

      S_ACQ: begin
        if (!enable) begin
          state_d     = S_IDLE;
          frame_cnt_d = '0;
        end else if (frame_end_hist) begin
          if (!last_frame) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            frame_cnt_d = '0;
            rd_start_d  = 1'b1;
            state_d     = S_RD_WAIT;
          end
        end
      end

      // Readout in flight: only rd_done moves us on, even if enable has dropped.
      S_RD_WAIT: begin
        if (rd_done) begin
          if (!enable) begin
            state_d = S_IDLE;
          end else if (next_chan != hist_switch_q) begin
            hist_switch_d  = next_chan;
            chan_changed_d = 1'b1;
            settle_cnt_d   = 8'(SETTLE_CYCLES);
            state_d        = S_SETTLE;
          end else begin
            state_d = S_ALIGN;
          end
        end
      end

      S_SETTLE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (settle_cnt_q <= 8'd1) begin
          state_d = S_ALIGN;
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end

      S_ALIGN: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (frame_end_hist) begin
          state_d = S_ACQ;
        end
      end

      default: begin
        state_d     = S_IDLE;
        frame_cnt_d = '0;
      end
    endcase

    hist_gate_d = (state_d == S_ACQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      hist_switch_q  <= RST_CHAN;
      hist_gate_q    <= 1'b0;
      rd_start_q     <= 1'b0;
      chan_changed_q <= 1'b0;
      frame_cnt_q    <= '0;
      settle_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      hist_switch_q  <= hist_switch_d;
      hist_gate_q    <= hist_gate_d;
      rd_start_q     <= rd_start_d;
      chan_changed_q <= chan_changed_d;
      frame_cnt_q    <= frame_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
    end
  end

  assign hist_switch  = hist_switch_q;
  assign hist_gate    = hist_gate_q;
  assign rd_start     = rd_start_q;
  assign chan_changed = chan_changed_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_hist_chan_sched.sv
// Bench for hist_chan_sched: two parameterisations share stimulus and are checked every cycle
// against a channel-index / phase model, plus directed sequence and corner checks.
module tb_hist_chan_sched;

  localparam int P_IDLE = 0;
  localparam int P_ACQ  = 1;
  localparam int P_RDW  = 2;
  localparam int P_SET  = 3;
  localparam int P_ALN  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic auto_mode = 1'b1;
  logic [3:0] manual_sel = 4'b0000;
  logic frame_end_hist = 1'b0;
  logic rd_done = 1'b0;

  logic [3:0] sw [2];
  logic       gate [2];
  logic       rs [2];
  logic       cc [2];
  logic [7:0] fc [2];

  always #5 clk = ~clk;

  hist_chan_sched #(.FRAMES_PER_CHAN(2), .SETTLE_CYCLES(4), .CHAN_MASK(4'b1111)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .auto_mode(auto_mode), .manual_sel(manual_sel),
    .frame_end_hist(frame_end_hist), .rd_done(rd_done),
    .hist_switch(sw[0]), .hist_gate(gate[0]), .rd_start(rs[0]), .chan_changed(cc[0]), .frame_cnt(fc[0])
  );

  hist_chan_sched #(.FRAMES_PER_CHAN(1), .SETTLE_CYCLES(3), .CHAN_MASK(4'b0101)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .auto_mode(auto_mode), .manual_sel(manual_sel),
    .frame_end_hist(frame_end_hist), .rd_done(rd_done),
    .hist_switch(sw[1]), .hist_gate(gate[1]), .rd_start(rs[1]), .chan_changed(cc[1]), .frame_cnt(fc[1])
  );

  int p_f [2] = '{2, 1};
  int p_s [2] = '{4, 3};
  logic [3:0] p_m [2] = '{4'b1111, 4'b0101};

  // Model: phase, channel as bit index (0=R..3=Y), frames done, cycles spent settling.
  int m_ph [2];
  int m_ch [2];
  int m_fc [2];
  int m_sc [2];
  bit m_rs [2];
  bit m_cc [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_cd = 0;
  bit rec = 1'b0;
  int cc_cnt = 0;
  logic [3:0] seq_a [$];
  logic [3:0] seq_b [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int next_ch(input int i);
    logic [3:0] mask;
    mask = (p_m[i] == 4'b0000) ? 4'b1000 : p_m[i];
    if (auto_mode) begin
      for (int k = 1; k <= 4; k++) begin
        if (mask[(m_ch[i] + k) % 4]) return (m_ch[i] + k) % 4;
      end
      return m_ch[i];
    end
    if ($countones(manual_sel) == 1) begin
      for (int c = 0; c < 4; c++) if (manual_sel[c]) return c;
    end
    return m_ch[i];
  endfunction

  task automatic step(input int i);
    int nx;
    m_rs[i] = 1'b0;
    m_cc[i] = 1'b0;
    if (reset) begin
      m_ph[i] = P_IDLE; m_ch[i] = 3; m_fc[i] = 0; m_sc[i] = 0;
      return;
    end
    case (m_ph[i])
      P_IDLE: if (enable && frame_end_hist) m_ph[i] = P_ACQ;
      P_ACQ: begin
        if (!enable) begin
          m_ph[i] = P_IDLE; m_fc[i] = 0;
        end else if (frame_end_hist) begin
          if (m_fc[i] + 1 < p_f[i]) m_fc[i]++;
          else begin m_fc[i] = 0; m_rs[i] = 1'b1; m_ph[i] = P_RDW; end
        end
      end
      P_RDW: begin
        if (rd_done) begin
          if (!enable) m_ph[i] = P_IDLE;
          else begin
            nx = next_ch(i);
            if (nx != m_ch[i]) begin
              m_ch[i] = nx; m_cc[i] = 1'b1; m_sc[i] = 0; m_ph[i] = P_SET;
            end else m_ph[i] = P_ALN;
          end
        end
      end
      P_SET: begin
        if (!enable) m_ph[i] = P_IDLE;
        else begin
          m_sc[i]++;
          if (m_sc[i] >= p_s[i]) m_ph[i] = P_ALN;
        end
      end
      default: begin
        if (!enable) m_ph[i] = P_IDLE;
        else if (frame_end_hist) m_ph[i] = P_ACQ;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) step(i);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("sw%0d", i), 32'(sw[i]), 32'(4'b0001 << m_ch[i]));
      chk($sformatf("gate%0d", i), 32'(gate[i]), 32'(m_ph[i] == P_ACQ));
      chk($sformatf("rd_start%0d", i), 32'(rs[i]), 32'(m_rs[i]));
      chk($sformatf("chg%0d", i), 32'(cc[i]), 32'(m_cc[i]));
      chk($sformatf("fcnt%0d", i), 32'(fc[i]), 32'(m_fc[i]));
    end
    if (rec && cc[0]) seq_a.push_back(sw[0]);
    if (rec && cc[1]) seq_b.push_back(sw[1]);
    if (cc[0]) cc_cnt++;
    @(negedge clk);
  endtask

  // Regular frames every 20 cycles; rd_done 10 cycles after A's readout request, coinciding with a frame end.
  task automatic frame_stim();
    if (m_rs[0] && rd_cd == 0) rd_cd = 10;
    rd_done = 1'b0;
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) rd_done = 1'b1;
    end
    frame_end_hist = ((cyc % 20) == 0) || rd_done;
  endtask

  task automatic rand_stim();
    reset = ($urandom_range(0, 399) == 0);
    if (enable) enable = ($urandom_range(0, 59) != 0);
    else        enable = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 199) == 0) auto_mode = ~auto_mode;
    if ($urandom_range(0, 79) == 0)
      manual_sel = $urandom_range(0, 1) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    frame_end_hist = ($urandom_range(0, 9) == 0);
    rd_done = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int guard;
    logic [3:0] held;
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = P_IDLE; m_ch[i] = 3; m_fc[i] = 0; m_sc[i] = 0; m_rs[i] = 0; m_cc[i] = 0;
    end
    @(negedge clk);
    repeat (3) tick();
    chk("rst_sw", 32'(sw[0]), 32'h8);
    chk("rst_gate", 32'(gate[0]), 32'h0);

    // Enabled but no frame boundary: accumulation must not start.
    reset = 1'b0;
    enable = 1'b1;
    repeat (100) tick();
    chk("no_frame_gate", 32'(gate[0]), 32'h0);
    frame_end_hist = 1'b1;
    tick();
    frame_end_hist = 1'b0;
    chk("first_gate", 32'(gate[0]), 32'h1);

    // Auto rotation sequences.
    rec = 1'b1;
    repeat (500) begin frame_stim(); tick(); end
    rec = 1'b0;
    chk("seq_a_len", 32'(seq_a.size() >= 4), 32'h1);
    if (seq_a.size() >= 4) begin
      chk("seq_a0", 32'(seq_a[0]), 32'h1);
      chk("seq_a1", 32'(seq_a[1]), 32'h2);
      chk("seq_a2", 32'(seq_a[2]), 32'h4);
      chk("seq_a3", 32'(seq_a[3]), 32'h8);
    end
    chk("seq_b_len", 32'(seq_b.size() >= 3), 32'h1);
    if (seq_b.size() >= 3) begin
      chk("seq_b0", 32'(seq_b[0]), 32'h1);
      chk("seq_b1", 32'(seq_b[1]), 32'h4);
      chk("seq_b2", 32'(seq_b[2]), 32'h1);
    end

    // Manual mode: valid one-hot then an invalid request.
    auto_mode = 1'b0;
    manual_sel = 4'b0010;
    repeat (300) begin frame_stim(); tick(); end
    chk("man_sw", 32'(sw[0]), 32'h2);
    manual_sel = 4'b0110;
    cc_cnt = 0;
    repeat (200) begin frame_stim(); tick(); end
    chk("man_bad_nochg", 32'(cc_cnt), 32'h0);

    // enable dropped during readout: wait for rd_done, keep channel, go idle.
    auto_mode = 1'b1;
    guard = 0;
    while (m_ph[0] != P_RDW && guard < 300) begin frame_stim(); tick(); guard++; end
    chk("reach_rdwait", 32'(m_ph[0] == P_RDW), 32'h1);
    rd_cd = 0;
    rd_done = 1'b0;
    frame_end_hist = 1'b0;
    enable = 1'b0;
    held = 4'(4'b0001 << m_ch[0]);
    repeat (5) tick();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tick();
    chk("drop_sw_held", 32'(sw[0]), 32'(held));
    chk("drop_gate", 32'(gate[0]), 32'h0);

    // reset while settling.
    enable = 1'b1;
    guard = 0;
    while (m_ph[0] != P_SET && guard < 600) begin frame_stim(); tick(); guard++; end
    chk("reach_settle", 32'(m_ph[0] == P_SET), 32'h1);
    rd_done = 1'b0;
    frame_end_hist = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("settle_rst_sw", 32'(sw[0]), 32'h8);
    chk("settle_rst_gate", 32'(gate[0]), 32'h0);
    chk("settle_rst_chg", 32'(cc[0]), 32'h0);
    chk("settle_rst_fcnt", 32'(fc[0]), 32'h0);
    rd_cd = 0;

    // Randomized traffic.
    repeat (4000) begin rand_stim(); tick(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
